// File: rtl/stage_wb_pkg.sv
// Shared definitions for the writeback stage: datapath width, wb_sel and
// load funct3 encodings, FSM state type and the W pipeline register layout.
package stage_wb_pkg;

    localparam int unsigned XLEN = 32;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Load width/sign encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } wb_state_e;

    // W pipeline register payload
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rd;
        logic            reg_wen;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
    } w_reg_t;

endpackage

// File: rtl/stage_wb_if.sv
// Bus bundle between the M stage / data memory (master side) and the
// writeback stage (slave side).
//   M-stage:  validM, alu_outM, pc4M, rdM, reg_wenM, wb_selM, funct3M
//   memory:   dmem_rdata, dmem_rvalid
//   results:  wb_en, wb_rd, wb_data, stall_req, load_err
interface stage_wb_if;

    logic                          validM;
    logic [stage_wb_pkg::XLEN-1:0] alu_outM;
    logic [stage_wb_pkg::XLEN-1:0] pc4M;
    logic [4:0]                    rdM;
    logic                          reg_wenM;
    logic [1:0]                    wb_selM;
    logic [2:0]                    funct3M;
    logic [stage_wb_pkg::XLEN-1:0] dmem_rdata;
    logic                          dmem_rvalid;
    logic                          wb_en;
    logic [4:0]                    wb_rd;
    logic [stage_wb_pkg::XLEN-1:0] wb_data;
    logic                          stall_req;
    logic                          load_err;

    modport master (
        output validM, alu_outM, pc4M, rdM, reg_wenM, wb_selM, funct3M,
        output dmem_rdata, dmem_rvalid,
        input  wb_en, wb_rd, wb_data, stall_req, load_err
    );

    modport slave (
        input  validM, alu_outM, pc4M, rdM, reg_wenM, wb_selM, funct3M,
        input  dmem_rdata, dmem_rvalid,
        output wb_en, wb_rd, wb_data, stall_req, load_err
    );

endinterface

// File: rtl/stage_wb_load_extend.sv
// load_extend: picks the addressed byte/halfword/word out of a memory word
// and sign- or zero-extends it; flags misaligned halfword/word accesses.
// Mirror of the store mask generator.
//   funct3     in  load width/sign
//   sft        in  byte offset within the word
//   rdata      in  word returned by data memory
//   data       out extended load value
//   misaligned out access not naturally aligned (data still extracted)
module load_extend
    import stage_wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      sft,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection
    always_comb begin
        byte_sel = rdata[7:0];
        case (sft)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = sft[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension and alignment check; unknown funct3 behaves as LW
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB: begin
                data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            end
            F3_LBU: begin
                data = {{(XLEN-8){1'b0}}, byte_sel};
            end
            F3_LH: begin
                data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = sft[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = sft[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (sft != 2'd0);
            end
            default: begin
                data       = rdata;
                misaligned = (sft != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/stage_wb.sv
// stage_wb: writeback stage. Registers the M instruction into W, waits for
// the data-memory response on loads (with timeout), and drives the
// register-file write port, upstream stall and forwarding value.
//   clk, rst_n   core clock, async active-low reset
//   bus (slave)  M-stage inputs, dmem response, writeback/stall/error outputs
module stage_wb
    import stage_wb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    stage_wb_if.slave  bus
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    w_reg_t          w_q;
    w_reg_t          w_d;
    wb_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic            load_err_q;

    logic            is_load_c;
    logic            timeout_c;
    logic            stall_c;
    logic            misaligned_c;
    logic [XLEN-1:0] ld_data_c;
    logic [XLEN-1:0] wb_data_c;

    load_extend u_load_extend (
        .funct3     (w_q.funct3),
        .sft        (w_q.alu_out[1:0]),
        .rdata      (bus.dmem_rdata),
        .data       (ld_data_c),
        .misaligned (misaligned_c)
    );

    // Load/stall decode; a response in the timeout cycle takes priority
    always_comb begin
        is_load_c = w_q.valid && (w_q.wb_sel == WB_MEM);
        timeout_c = (state_q == S_WAIT) && (cnt_q == CW'(MAX_WAIT)) && !bus.dmem_rvalid;
        stall_c   = is_load_c && !bus.dmem_rvalid && !timeout_c;
    end

    always_comb begin
        w_d.valid   = bus.validM;
        w_d.alu_out = bus.alu_outM;
        w_d.pc4     = bus.pc4M;
        w_d.rd      = bus.rdM;
        w_d.reg_wen = bus.reg_wenM;
        w_d.wb_sel  = bus.wb_selM;
        w_d.funct3  = bus.funct3M;
    end

    // W pipeline register, frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else if (!stall_c) begin
            w_q <= w_d;
        end
    end

    // Wait FSM. cnt_q counts stalled cycles of the current load, so the
    // timeout cycle is the one after MAX_WAIT stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (stall_c) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (!stall_c) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Sticky error: load timeout or misaligned load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_q <= 1'b0;
        end else if (timeout_c || (is_load_c && misaligned_c)) begin
            load_err_q <= 1'b1;
        end
    end

    // Writeback value; reserved wb_sel falls back to the ALU result
    always_comb begin
        wb_data_c = w_q.alu_out;
        case (w_q.wb_sel)
            WB_MEM:  wb_data_c = ld_data_c;
            WB_PC4:  wb_data_c = w_q.pc4;
            default: wb_data_c = w_q.alu_out;
        endcase
        if (timeout_c) begin
            wb_data_c = '0;
        end
    end

    assign bus.wb_en     = w_q.valid && w_q.reg_wen && (w_q.rd != 5'd0)
                           && (!is_load_c || bus.dmem_rvalid || timeout_c);
    assign bus.wb_rd     = w_q.rd;
    assign bus.wb_data   = wb_data_c;
    assign bus.stall_req = stall_c;
    assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_stage_wb.sv
module tb_stage_wb;
    import stage_wb_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    wb_exp_t sb[$];

    stage_wb_if bus ();

    stage_wb #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_m(input logic v, input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                           input logic [2:0] f3);
        bus.validM   = v;
        bus.alu_outM = alu;
        bus.pc4M     = pc4;
        bus.rdM      = rd;
        bus.reg_wenM = wen;
        bus.wb_selM  = sel;
        bus.funct3M  = f3;
    endtask

    task automatic bubble();
        drive_m(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, WB_ALU, 3'b000);
    endtask

    task automatic mem(input logic rv, input logic [31:0] rd);
        bus.dmem_rvalid = rv;
        bus.dmem_rdata  = rd;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    // Sample at negedge, compare handshake outputs and any write, then advance
    task automatic run_cycle(input string tag, input logic exp_en, input logic exp_stall);
        wb_exp_t e;
        @(negedge clk);
        check({tag, "_wb_en"}, 32'(bus.wb_en), 32'(exp_en));
        check({tag, "_stall"}, 32'(bus.stall_req), 32'(exp_stall));
        if (bus.wb_en === 1'b1) begin
            if (sb.size() == 0) begin
                check({tag, "_unexpected_write"}, 32'(bus.wb_rd), 32'h0);
            end else begin
                e = sb.pop_front();
                check({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(e.rd));
                check({tag, "_wb_data"}, bus.wb_data, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wb_en"}, 32'(bus.wb_en), 32'h0);
        check({tag, "_stall"}, 32'(bus.stall_req), 32'h0);
        check({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'h0);
        check({tag, "_wb_data"}, bus.wb_data, 32'h0);
        check({tag, "_load_err"}, 32'(bus.load_err), 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bubble();
        mem(1'b0, 32'h0);

        // Reset state
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD x5 -> written the cycle after M
        drive_m(1'b1, 32'h0000_0010, 32'h0000_0104, 5'd5, 1'b1, WB_ALU, 3'b000);
        push(5'd5, 32'h0000_0010);
        run_cycle("add_m", 1'b0, 1'b0);
        bubble();
        run_cycle("add_w", 1'b1, 1'b0);

        // rvalid outside a W load is ignored
        mem(1'b1, 32'hDEAD_BEEF);
        run_cycle("stray_rvalid", 1'b0, 1'b0);
        mem(1'b0, 32'h0);

        // LB x6, sft=3, single-cycle memory
        drive_m(1'b1, 32'h0000_0103, 32'h0, 5'd6, 1'b1, WB_MEM, F3_LB);
        push(5'd6, 32'hFFFF_FF80);
        run_cycle("lb_m", 1'b0, 1'b0);
        bubble();
        mem(1'b1, 32'h80FF_1234);
        run_cycle("lb_w", 1'b1, 1'b0);
        mem(1'b0, 32'h0);

        // LHU x7, sft=2, response after 3 stall cycles; next instr held behind it
        drive_m(1'b1, 32'h0000_0202, 32'h0, 5'd7, 1'b1, WB_MEM, F3_LHU);
        push(5'd7, 32'h0000_BEEF);
        run_cycle("lhu_m", 1'b0, 1'b0);
        drive_m(1'b1, 32'h0000_0055, 32'h0, 5'd8, 1'b1, WB_ALU, 3'b000);
        push(5'd8, 32'h0000_0055);
        for (int i = 0; i < 3; i++) run_cycle("lhu_wait", 1'b0, 1'b1);
        mem(1'b1, 32'hBEEF_0000);
        run_cycle("lhu_resp", 1'b1, 1'b0);
        mem(1'b0, 32'h0);
        bubble();
        run_cycle("lhu_next", 1'b1, 1'b0);
        check("lhu_load_err", 32'(bus.load_err), 32'h0);

        // LW x9 never answered -> 15 stall cycles then zero write and sticky error
        drive_m(1'b1, 32'h0000_0300, 32'h0, 5'd9, 1'b1, WB_MEM, F3_LW);
        push(5'd9, 32'h0);
        run_cycle("lw_to_m", 1'b0, 1'b0);
        drive_m(1'b1, 32'h0000_0077, 32'h0, 5'd10, 1'b1, WB_ALU, 3'b000);
        push(5'd10, 32'h0000_0077);
        for (int i = 0; i < 15; i++) run_cycle("lw_to_wait", 1'b0, 1'b1);
        run_cycle("lw_to_timeout", 1'b1, 1'b0);
        bubble();
        run_cycle("lw_to_next", 1'b1, 1'b0);
        check("lw_to_load_err", 32'(bus.load_err), 32'h1);
        run_cycle("lw_to_idle", 1'b0, 1'b0);
        check("lw_to_err_sticky", 32'(bus.load_err), 32'h1);

        // Clear error, then misaligned LH x11 followed by JAL x0 and JAL x1
        rst_n = 1'b0;
        #2;
        check("rst1_load_err", 32'(bus.load_err), 32'h0);
        rst_n = 1'b1;
        drive_m(1'b1, 32'h0000_0401, 32'h0, 5'd11, 1'b1, WB_MEM, F3_LH);
        push(5'd11, 32'hFFFF_ABCD);
        run_cycle("lh_mis_m", 1'b0, 1'b0);
        drive_m(1'b1, 32'h0, 32'h0000_1000, 5'd0, 1'b1, WB_PC4, 3'b000);
        mem(1'b1, 32'h1234_ABCD);
        run_cycle("lh_mis_w", 1'b1, 1'b0);
        mem(1'b0, 32'h0);
        check("lh_mis_load_err", 32'(bus.load_err), 32'h1);
        drive_m(1'b1, 32'h0, 32'h0000_2004, 5'd1, 1'b1, WB_PC4, 3'b000);
        push(5'd1, 32'h0000_2004);
        run_cycle("jal_x0", 1'b0, 1'b0);
        bubble();
        run_cycle("jal_x1", 1'b1, 1'b0);

        // Reset during WAIT drops the pending load
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive_m(1'b1, 32'h0000_0500, 32'h0, 5'd12, 1'b1, WB_MEM, F3_LW);
        run_cycle("rstw_m", 1'b0, 1'b0);
        bubble();
        run_cycle("rstw_w0", 1'b0, 1'b1);
        run_cycle("rstw_w1", 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        check_idle_outputs("rstw_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem(1'b1, 32'h1111_2222);
        run_cycle("rstw_late_rvalid", 1'b0, 1'b0);
        mem(1'b0, 32'h0);

        // Response coincides with the timeout count: real data, no error
        drive_m(1'b1, 32'h0000_0600, 32'h0, 5'd13, 1'b1, WB_MEM, F3_LW);
        push(5'd13, 32'hCAFE_F00D);
        run_cycle("tie_m", 1'b0, 1'b0);
        bubble();
        for (int i = 0; i < 15; i++) run_cycle("tie_wait", 1'b0, 1'b1);
        mem(1'b1, 32'hCAFE_F00D);
        run_cycle("tie_resp", 1'b1, 1'b0);
        mem(1'b0, 32'h0);
        run_cycle("tie_after", 1'b0, 1'b0);
        check("tie_load_err", 32'(bus.load_err), 32'h0);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stage_wb.md
# stage_wb

Writeback stage of the 3-stage RISC-V core. It sits directly downstream of the memory-address stage and registers the M-stage instruction into a W pipeline register. For loads it waits for the data-memory response, extracts and extends the addressed byte/halfword/word, and selects the final writeback value. It drives the register-file write port, a stall request back to the upstream stages, and a bypass value for forwarding.

## Interface
- `XLEN`, 32, datapath width (from `defines.v`)
- `MAX_WAIT`, 15, maximum cycles a load may wait for `dmem_rvalid` before timeout; counter width is `$clog2(MAX_WAIT+1)`
- `clk` in 1: single core clock; all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `validM` in 1: M-stage slot holds a real instruction
- `alu_outM` in XLEN: ALU result; low 2 bits are the load byte offset
- `pc4M` in XLEN: PC+4 of the M instruction (JAL/JALR link)
- `rdM` in 5: destination register
- `reg_wenM` in 1: instruction writes rd
- `wb_selM` in 2: 00 ALU, 01 MEM, 10 PC4, 11 reserved (treated as ALU)
- `funct3M` in 3: load width/sign
- `dmem_rdata` in XLEN: word read from data memory
- `dmem_rvalid` in 1: `dmem_rdata` valid this cycle
- `wb_en` out 1: register-file write enable
- `wb_rd` out 5: write address
- `wb_data` out XLEN: write data, also the forwarding bypass value
- `stall_req` out 1: hold all upstream stages this cycle
- `load_err` out 1: sticky; set on load timeout or misaligned access

## Operation
- W register captures `validM`, `alu_outM`, `pc4M`, `rdM`, `reg_wenM`, `wb_selM`, `funct3M` on every edge where `stall_req`=0. It holds its contents when `stall_req`=1.
- Load = W valid and `wb_sel`=01.
- FSM states:
  - IDLE
    - Enters WAIT at the edge after a load sits in W with `dmem_rvalid`=0.
  - WAIT
    - Returns to IDLE on `dmem_rvalid`=1, or when the wait counter reaches `MAX_WAIT`.
- `stall_req` = W load & !`dmem_rvalid` & !timeout. It is combinational, so the response cycle releases the stall in that same cycle.
- Wait counter:
  - Clears on entry to WAIT.
  - Increments each WAIT cycle.
  - Timeout is asserted when count == `MAX_WAIT`.
- Load extraction, with `sft` = `alu_out[1:0]`:
  - funct3 000 LB: sign-extends byte `sft`.
  - 100 LBU: zero-extends byte `sft`.
  - 001 LH: sign-extends halfword `sft[1]`.
  - 101 LHU: zero-extends halfword `sft[1]`.
  - 010 LW: passes the full word.
  - Other funct3 values: treated as LW.
- Misalignment:
  - Halfword with `sft[0]`=1, or word with `sft`≠0, sets `load_err`.
  - The data is still extracted as above.
- `wb_data` mux:
  - ALU → `alu_out`
  - MEM → extracted load
  - PC4 → `pc4`
  - On timeout: 0, and `load_err` is set.
- `wb_en` = W valid & `reg_wen` & (`wb_rd`≠0) & (not a load, or `dmem_rvalid`, or timeout).
- `wb_rd` = W `rd`.

## Timing
- Reset values:
  - W valid 0, state IDLE, counter 0, `load_err` 0.
  - Outputs: `wb_en` 0, `stall_req` 0, `wb_rd` 0, `wb_data` 0.
- Non-load latency: the instruction writes back in the cycle after it leaves M (one-cycle register).
- Load with 1-cycle memory: `dmem_rvalid`=1 in the first W cycle, so there is no stall and `wb_en` is asserted that cycle.
- Load with N extra cycles: `stall_req` is high for N cycles. `wb_en` is asserted in the `rvalid` cycle, and the next M instruction enters W at that edge.
- `dmem_rvalid` is ignored outside a W load: there is no state change and no write.
- `dmem_rvalid` arriving in the same cycle as timeout: `rvalid` wins, real data is written, and there is no error.
- `rst_n` low mid-WAIT clears everything asynchronously. The pending load is dropped and never written.
- `load_err` clears only on reset.

## Structure
- Add to the shared `defines.v` package:
  - `wb_sel` encodings (`WB_ALU`, `WB_MEM`, `WB_PC4`)
  - load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`)
- One combinational sub-module, `load_extend`, with inputs `funct3`, `sft`, `rdata` and outputs `data` and `misaligned`. It is the mirror of the store mask generator.
- FSM, counter and W register stay in `stage_wb`.

## Test plan
- ADD x5 (`alu_out`=0x0000_0010, `wb_sel`=00) → next cycle `wb_en`=1, `wb_rd`=5, `wb_data`=0x10, `stall_req`=0.
- LB x6, `sft`=3, `rdata`=0x80FF_1234, `rvalid` first cycle → `wb_data`=0xFFFF_FF80, no stall.
- LHU x7, `sft`=2, `rdata`=0xBEEF_0000, `rvalid` after 3 cycles → `stall_req`=1 for 3 cycles, then `wb_data`=0x0000_BEEF; the following instruction is held and then written back the cycle after.
- LW, `rvalid` never asserted, `MAX_WAIT`=15 → stall for 15 cycles, then `wb_en`=1 with `wb_data`=0, `load_err`=1 sticky.
- LH with `sft`=1, and separately a JAL with `rd`=0 → first sets `load_err`; second gives `wb_en`=0.
- `rst_n` pulsed low during WAIT → all outputs 0 immediately, state IDLE, and a late `rvalid` produces no write.
